// File: rtl/peak_extractor_if.sv
// Event output channel of the peak extractor: one peak report per transfer.
//
// Handshake: a transfer happens at every posedge where OUT_VALID and OUT_READY
// are both 1. While OUT_VALID=1 and no transfer has happened, the producer holds
// OUT_AMP/OUT_TS/OUT_PILEUP stable. OUT_VALID never depends combinationally on
// OUT_READY. The consumer may drive OUT_READY freely.
interface peak_extractor_if #(
  parameter int DATA_W = 8,
  parameter int TS_W   = 16
);
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic signed [DATA_W-1:0] OUT_AMP;
  logic [TS_W-1:0]          OUT_TS;
  logic                     OUT_PILEUP;

  modport master (
    output OUT_VALID,
    output OUT_AMP,
    output OUT_TS,
    output OUT_PILEUP,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_AMP,
    input  OUT_TS,
    input  OUT_PILEUP,
    output OUT_READY
  );
endinterface

// File: rtl/peak_extractor.sv
// Peak extractor: watches a free-running signed sample stream, finds each pulse
// above THRESHOLD, and reports its peak amplitude and timestamp through a
// single-entry output buffer. Over-long pulses are reported as pile-up; events
// that find the buffer occupied are counted in a saturating drop counter.
module peak_extractor #(
  parameter int DATA_W    = 8,
  parameter int THRESHOLD = 20,
  parameter int HOLDOFF   = 12,
  parameter int MAX_WIDTH = 32,
  parameter int TS_W      = 16,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] IN,
  peak_extractor_if.master         evt,
  output logic [CNT_W-1:0]         DROP_CNT,
  output logic                     BUSY
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RISE     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  // Width counter only ever holds 1..MAX_WIDTH-1; the pile-up emit fires instead
  // of reaching MAX_WIDTH.
  localparam int WID_W = $clog2(MAX_WIDTH + 1);
  localparam logic [WID_W-1:0] WID_LAST = WID_W'(MAX_WIDTH - 1);

  localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  // With no holdoff a closed pulse returns straight to IDLE.
  localparam logic [1:0] ST_CLOSE = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;

  logic [1:0]               state, state_nx;
  logic signed [DATA_W-1:0] max_amp, max_nx;
  logic [TS_W-1:0]          max_ts, max_ts_nx;
  logic [WID_W-1:0]         width, width_nx;
  logic [HOLD_W-1:0]        hold_cnt, hold_nx;
  logic [TS_W-1:0]          ts;
  logic                     high;
  logic                     emit;
  logic                     emit_pile;
  logic                     buf_free;

  // Signed comparison: int'() sign-extends the sample.
  assign high = (int'(IN) > THRESHOLD);

  // Buffer can take a new event if empty or being drained on this same edge.
  assign buf_free = !evt.OUT_VALID || evt.OUT_READY;

  // Next-state, running-max and emit decision for the pulse tracker.
  always_comb begin
    state_nx  = state;
    max_nx    = max_amp;
    max_ts_nx = max_ts;
    width_nx  = width;
    hold_nx   = hold_cnt;
    emit      = 1'b0;
    emit_pile = 1'b0;
    case (state)
      ST_IDLE: begin
        if (high) begin
          state_nx  = ST_RISE;
          max_nx    = IN;
          max_ts_nx = ts;
          width_nx  = WID_W'(1);
        end
      end
      ST_RISE: begin
        if (!high) begin
          // Falling sample closes the pulse and is not a peak candidate.
          emit     = 1'b1;
          state_nx = ST_CLOSE;
          hold_nx  = HOLD_LOAD;
        end else begin
          // Strict '>' keeps the earliest timestamp on a plateau.
          if (IN > max_amp) begin
            max_nx    = IN;
            max_ts_nx = ts;
          end
          if (width == WID_LAST) begin
            emit      = 1'b1;
            emit_pile = 1'b1;
            state_nx  = ST_WAIT_LOW;
          end else begin
            width_nx = width + WID_W'(1);
          end
        end
      end
      ST_WAIT_LOW: begin
        if (!high) begin
          state_nx = ST_CLOSE;
          hold_nx  = HOLD_LOAD;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == '0) state_nx = ST_IDLE;
        else                hold_nx  = hold_cnt - HOLD_W'(1);
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Pulse tracker registers, timestamp counter and BUSY flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      max_amp  <= '0;
      max_ts   <= '0;
      width    <= '0;
      hold_cnt <= '0;
      ts       <= '0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nx;
      max_amp  <= max_nx;
      max_ts   <= max_ts_nx;
      width    <= width_nx;
      hold_cnt <= hold_nx;
      ts       <= ts + TS_W'(1);
      BUSY     <= (state_nx != ST_IDLE);
    end
  end

  // Single-entry output buffer with saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      evt.OUT_VALID  <= 1'b0;
      evt.OUT_AMP    <= '0;
      evt.OUT_TS     <= '0;
      evt.OUT_PILEUP <= 1'b0;
      DROP_CNT       <= '0;
    end else if (emit) begin
      if (buf_free) begin
        evt.OUT_VALID  <= 1'b1;
        evt.OUT_AMP    <= max_nx;
        evt.OUT_TS     <= max_ts_nx;
        evt.OUT_PILEUP <= emit_pile;
      end else if (DROP_CNT != '1) begin
        DROP_CNT <= DROP_CNT + CNT_W'(1);
      end
    end else if (evt.OUT_VALID && evt.OUT_READY) begin
      evt.OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_peak_extractor.sv
// Testbench for peak_extractor: directed scenarios plus randomized traffic,
// compared every cycle against a pulse-level reference model.
module tb_peak_extractor;

  localparam int DATA_W    = 8;
  localparam int THRESHOLD = 20;
  localparam int HOLDOFF   = 12;
  localparam int MAX_WIDTH = 32;
  localparam int TS_W      = 16;
  localparam int CNT_W     = 8;
  localparam int W         = 1 + TS_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic signed [DATA_W-1:0] sample = '0;
  logic [CNT_W-1:0]         drop_cnt;
  logic                     busy;

  always #5 clk = ~clk;

  peak_extractor_if #(.DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  initial bus.OUT_READY = 1'b0;

  peak_extractor #(
    .DATA_W(DATA_W), .THRESHOLD(THRESHOLD), .HOLDOFF(HOLDOFF),
    .MAX_WIDTH(MAX_WIDTH), .TS_W(TS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .IN(sample),
    .evt(bus),
    .DROP_CNT(drop_cnt),
    .BUSY(busy)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int hs_cnt = 0;
  logic [W-1:0] last_hs;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pulse-level view: collect the samples of the current pulse and pick the
  // peak when the pulse closes; holdoff is a count of samples to skip.
  localparam int M_IDLE = 0, M_PULSE = 1, M_WAIT = 2, M_HOLD = 3;
  int                       m_mode = M_IDLE;
  int                       hold_left = 0;
  logic signed [DATA_W-1:0] pulse_amp[$];
  logic [TS_W-1:0]          pulse_ts[$];
  logic [TS_W-1:0]          m_ts = '0;
  logic                     m_valid = 1'b0;
  logic signed [DATA_W-1:0] m_amp = '0;
  logic [TS_W-1:0]          m_ts_out = '0;
  logic                     m_pile = 1'b0;
  logic [CNT_W-1:0]         m_drop = '0;
  logic                     m_busy = 1'b0;

  task automatic close_pulse();
    if (HOLDOFF == 0) m_mode = M_IDLE;
    else begin
      m_mode    = M_HOLD;
      hold_left = HOLDOFF;
    end
  endtask

  task automatic model_edge(input logic signed [DATA_W-1:0] s, input logic rdy, input logic rst);
    logic emit;
    logic e_pile;
    logic signed [DATA_W-1:0] pk_amp;
    logic [TS_W-1:0] pk_ts;
    logic accept;
    if (rst) begin
      m_mode = M_IDLE; hold_left = 0;
      pulse_amp.delete(); pulse_ts.delete();
      m_ts = '0; m_valid = 1'b0; m_amp = '0; m_ts_out = '0; m_pile = 1'b0;
      m_drop = '0; m_busy = 1'b0;
      return;
    end
    emit = 1'b0; e_pile = 1'b0;
    case (m_mode)
      M_IDLE: if (int'(s) > THRESHOLD) begin
        pulse_amp.delete(); pulse_ts.delete();
        pulse_amp.push_back(s); pulse_ts.push_back(m_ts);
        m_mode = M_PULSE;
      end
      M_PULSE: if (int'(s) <= THRESHOLD) begin
        emit = 1'b1;
        close_pulse();
      end else begin
        pulse_amp.push_back(s); pulse_ts.push_back(m_ts);
        if (pulse_amp.size() == MAX_WIDTH) begin
          emit = 1'b1; e_pile = 1'b1; m_mode = M_WAIT;
        end
      end
      M_WAIT: if (int'(s) <= THRESHOLD) close_pulse();
      default: begin
        hold_left--;
        if (hold_left == 0) m_mode = M_IDLE;
      end
    endcase
    pk_amp = '0; pk_ts = '0;
    if (emit) begin
      pk_amp = pulse_amp[0]; pk_ts = pulse_ts[0];
      foreach (pulse_amp[i]) if (pulse_amp[i] > pk_amp) begin
        pk_amp = pulse_amp[i]; pk_ts = pulse_ts[i];
      end
    end
    accept = m_valid && rdy;
    if (accept) exp_q.push_back({m_pile, m_ts_out, m_amp});
    if (emit) begin
      if (!m_valid || accept) begin
        m_valid = 1'b1; m_amp = pk_amp; m_ts_out = pk_ts; m_pile = e_pile;
      end else if (m_drop != '1) m_drop = m_drop + 1'b1;
    end else if (accept) m_valid = 1'b0;
    m_busy = (m_mode != M_IDLE);
    m_ts = m_ts + 1'b1;
  endtask

  // ---------------- driver ----------------
  task automatic step(input int s_in, input logic rdy, input logic rst);
    logic cap_valid;
    logic [W-1:0] cap_word;
    logic [W-1:0] e;
    @(negedge clk);
    sample        = DATA_W'(s_in);
    bus.OUT_READY = rdy;
    reset         = rst;
    cap_valid     = bus.OUT_VALID;
    cap_word      = {bus.OUT_PILEUP, bus.OUT_TS, bus.OUT_AMP};
    @(posedge clk);
    model_edge(DATA_W'(s_in), rdy, rst);
    if (cap_valid && rdy && !rst) begin
      hs_cnt++;
      last_hs = cap_word;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_event", 32'(cap_word), 32'(e));
      end
    end
    #1;
    chk("valid", 32'(bus.OUT_VALID), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (m_valid) begin
      chk("amp", 32'(bus.OUT_AMP), 32'(m_amp));
      chk("ts", 32'(bus.OUT_TS), 32'(m_ts_out));
      chk("pileup", 32'(bus.OUT_PILEUP), 32'(m_pile));
    end
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, rdy, 1'b0);
  endtask

  task automatic run_seq(input int vals[], input logic rdy);
    foreach (vals[i]) step(vals[i], rdy, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [TS_W-1:0] t_mark;
    int hs0;
    int seglen;
    bit seg_high;
    logic rdy;

    // Reset state
    step(0, 1'b0, 1'b1);
    step(0, 1'b0, 1'b1);
    chk("rst_valid", 32'(bus.OUT_VALID), 32'(0));
    chk("rst_amp", 32'(bus.OUT_AMP), 32'(0));
    chk("rst_ts", 32'(bus.OUT_TS), 32'(0));
    chk("rst_pile", 32'(bus.OUT_PILEUP), 32'(0));
    chk("rst_drop", 32'(drop_cnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));

    // 1. Single pulse
    hs0 = hs_cnt;
    run_seq('{0, 0, 10, 30}, 1'b1);
    t_mark = m_ts;
    run_seq('{50, 40, 25, 15}, 1'b1);
    chk("t1_valid_after_fall", 32'(bus.OUT_VALID), 32'(1));
    chk("t1_amp", 32'(bus.OUT_AMP), 32'(50));
    chk("t1_ts", 32'(bus.OUT_TS), 32'(t_mark));
    chk("t1_pile", 32'(bus.OUT_PILEUP), 32'(0));
    step(0, 1'b1, 1'b0);
    chk("t1_valid_one_cycle", 32'(bus.OUT_VALID), 32'(0));
    idle(14, 1'b1);
    chk("t1_hs_count", 32'(hs_cnt - hs0), 32'(1));

    // 2. Plateau keeps the first peak timestamp
    step(30, 1'b1, 1'b0);
    t_mark = m_ts;
    run_seq('{50, 50, 50, 10}, 1'b1);
    chk("t2_amp", 32'(bus.OUT_AMP), 32'(50));
    chk("t2_ts_first", 32'(bus.OUT_TS), 32'(t_mark));
    idle(14, 1'b1);

    // 3. Backpressure: second event dropped, first held stable
    hs0 = hs_cnt;
    run_seq('{30, 40, 0}, 1'b0);
    idle(13, 1'b0);
    run_seq('{30, 70, 0}, 1'b0);
    idle(14, 1'b0);
    chk("t3_drop", 32'(drop_cnt), 32'(1));
    chk("t3_held_valid", 32'(bus.OUT_VALID), 32'(1));
    chk("t3_held_amp", 32'(bus.OUT_AMP), 32'(40));
    step(0, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("t3_hs_count", 32'(hs_cnt - hs0), 32'(1));
    chk("t3_hs_amp", 32'(last_hs[DATA_W-1:0]), 32'(40));

    // 4. Holdoff suppresses an early pulse; a pulse at the first IDLE cycle counts
    hs0 = hs_cnt;
    run_seq('{30, 45, 0}, 1'b1);
    idle(4, 1'b1);
    run_seq('{30, 60, 60, 30, 25, 0}, 1'b1);
    idle(2, 1'b1);
    run_seq('{30, 60, 0}, 1'b1);
    idle(14, 1'b1);
    chk("t4_hs_count", 32'(hs_cnt - hs0), 32'(2));
    chk("t4_last_amp", 32'(last_hs[DATA_W-1:0]), 32'(60));

    // 5. Pile-up
    hs0 = hs_cnt;
    for (int i = 1; i <= 50; i++) begin
      step(60, 1'b1, 1'b0);
      if (i == MAX_WIDTH) begin
        chk("t5_valid", 32'(bus.OUT_VALID), 32'(1));
        chk("t5_pile", 32'(bus.OUT_PILEUP), 32'(1));
        chk("t5_amp", 32'(bus.OUT_AMP), 32'(60));
      end
    end
    step(0, 1'b1, 1'b0);
    chk("t5_busy_close", 32'(busy), 32'(1));
    idle(11, 1'b1);
    chk("t5_busy_hold", 32'(busy), 32'(1));
    step(0, 1'b1, 1'b0);
    chk("t5_busy_end", 32'(busy), 32'(0));
    chk("t5_hs_count", 32'(hs_cnt - hs0), 32'(1));

    // 6. Negative samples never trigger
    hs0 = hs_cnt;
    for (int i = 0; i < 20; i++) begin
      step(-100, 1'b1, 1'b0);
      chk("t6_neg_busy", 32'(busy), 32'(0));
    end
    chk("t6_neg_hs", 32'(hs_cnt - hs0), 32'(0));

    // 6b. Reset mid-pulse discards the pulse
    run_seq('{30, 50}, 1'b1);
    step(50, 1'b1, 1'b1);
    chk("t6_rst_valid", 32'(bus.OUT_VALID), 32'(0));
    chk("t6_rst_amp", 32'(bus.OUT_AMP), 32'(0));
    chk("t6_rst_ts", 32'(bus.OUT_TS), 32'(0));
    chk("t6_rst_busy", 32'(busy), 32'(0));
    hs0 = hs_cnt;
    run_seq('{0, 0, 0, 30, 55, 0}, 1'b1);
    chk("t6_clean_amp", 32'(bus.OUT_AMP), 32'(55));
    chk("t6_clean_ts", 32'(bus.OUT_TS), 32'(4));
    idle(14, 1'b1);
    chk("t6_clean_hs", 32'(hs_cnt - hs0), 32'(1));

    // Randomized traffic
    for (int seg = 0; seg < 150; seg++) begin
      seglen   = $urandom_range(1, 40);
      seg_high = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < seglen; i++) begin
        rdy = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 499) == 0) step(0, rdy, 1'b1);
        else if (seg_high) step($urandom_range(21, 127), rdy, 1'b0);
        else step(int'($urandom_range(0, 148)) - 128, rdy, 1'b0);
      end
    end

    // Drop counter saturation
    for (int i = 0; i < 300; i++) begin
      run_seq('{30, 0}, 1'b0);
      idle(HOLDOFF + 1, 1'b0);
    end
    chk("sat_drop", 32'(drop_cnt), 32'(8'hFF));

    // Timestamp wrap: peak on 0xFFFF, next pulse gets a wrapped small ts
    step(0, 1'b1, 1'b1);
    while (m_ts != 16'hFFFE) step(0, 1'b1, 1'b0);
    run_seq('{30, 50, 0}, 1'b1);
    chk("wrap_ts_ffff", 32'(bus.OUT_TS), 32'(16'hFFFF));
    chk("wrap_amp", 32'(bus.OUT_AMP), 32'(50));
    idle(13, 1'b1);
    run_seq('{30, 40, 0}, 1'b1);
    chk("wrap_next_ts", 32'(bus.OUT_TS), 32'(15));
    idle(3, 1'b1);

    chk("sb_drain", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
